pe_vec_mac: RTL and testbench

- Parametrised successor to the single-lane processing element: LANES parallel signed WIDTH×WIDTH multipliers feeding an adder tree plus incoming partial sum.
- Weight-stationary: the weight vector is held until reloaded.
- Data and psum arrive on independent update strobes; a compute issues only when all operands are present.
- Sits in the systolic PE grid; out_psum feeds the next PE's in_psum.

---
 rtl/pe_vec_mac.sv | 170 +++++++++++++++++
 tb/tb_pe_vec_mac.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_vec_mac.sv
// Weight-stationary vector MAC processing element: LANES signed multipliers, adder tree, incoming psum.
// Optional clamping of the result to the PSUM_W range is enabled by defining PE_VEC_SAT_EN.
`default_nettype none

module pe_vec_mac #(
  parameter int WIDTH          = 8,
  parameter int LANES          = 4,
  parameter int PSUM_W         = 20,
  parameter int PIPELINE_STAGE = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES*WIDTH-1:0] in_weight,
  input  logic [PSUM_W-1:0]      in_psum,
  input  logic                   in_data_update,
  input  logic                   in_weight_update,
  input  logic                   in_psum_update,
  output logic [PSUM_W-1:0]      out_psum,
  output logic                   out_psum_vld,
  output logic                   out_drop,
  output logic                   out_sat
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int SUM_W  = PSUM_W + 1;
  localparam int DLY    = PIPELINE_STAGE - 2;

  logic [LANES*WIDTH-1:0] weight_reg;
  logic                   weight_ok;
  logic [PSUM_W-1:0]      psum_reg;
  logic                   psum_ok;

  logic [LANES*WIDTH-1:0] weight_eff;
  logic [PSUM_W-1:0]      psum_eff;
  logic                   fire;

  assign weight_eff = in_weight_update ? in_weight : weight_reg;
  assign psum_eff   = in_psum_update ? in_psum : psum_reg;
  assign fire       = in_data_update & (weight_ok | in_weight_update) & (psum_ok | in_psum_update);

  always_ff @(posedge clk) begin
    if (!rst) begin
      weight_reg <= '0;
      weight_ok  <= 1'b0;
      psum_reg   <= '0;
      psum_ok    <= 1'b0;
      out_drop   <= 1'b0;
    end else begin
      if (in_weight_update) begin
        weight_reg <= in_weight;
        weight_ok  <= 1'b1;
      end
      if (in_psum_update)
        psum_reg <= in_psum;
      // A compute consumes the psum, including one loaded in the same cycle.
      if (fire)
        psum_ok <= 1'b0;
      else if (in_psum_update)
        psum_ok <= 1'b1;
      out_drop <= in_data_update & ~fire;
    end
  end

  // Operands are sign-extended to the product width so the low bits of the product are the signed result.
  logic [PROD_W-1:0] prod [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PROD_W-1:0] d_ext;
    logic [PROD_W-1:0] w_ext;
    assign d_ext   = {{WIDTH{in_data[i*WIDTH+WIDTH-1]}}, in_data[i*WIDTH +: WIDTH]};
    assign w_ext   = {{WIDTH{weight_eff[i*WIDTH+WIDTH-1]}}, weight_eff[i*WIDTH +: WIDTH]};
    assign prod[i] = d_ext * w_ext;
  end

  logic [PROD_W-1:0] s1_prod [LANES];
  logic [PSUM_W-1:0] s1_psum;
  logic              s1_vld;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_psum <= '0;
      for (int i = 0; i < LANES; i++) s1_prod[i] <= '0;
    end else begin
      s1_vld <= fire;
      if (fire) begin
        s1_psum <= psum_eff;
        for (int i = 0; i < LANES; i++) s1_prod[i] <= prod[i];
      end
    end
  end

  logic [SUM_W-1:0]  sum_full;
  logic [PSUM_W-1:0] sum_red;
  logic              sum_ovf;

  always_comb begin
    sum_full = {s1_psum[PSUM_W-1], s1_psum};
    for (int i = 0; i < LANES; i++)
      sum_full = sum_full + {{(SUM_W-PROD_W){s1_prod[i][PROD_W-1]}}, s1_prod[i]};
  end

`ifdef PE_VEC_SAT_EN
  always_comb begin
    sum_ovf = sum_full[SUM_W-1] ^ sum_full[PSUM_W-1];
    if (sum_ovf)
      sum_red = sum_full[SUM_W-1] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
    else
      sum_red = sum_full[PSUM_W-1:0];
  end
`else
  logic unused_sum_msb;
  assign unused_sum_msb = sum_full[SUM_W-1];
  assign sum_ovf        = 1'b0;
  assign sum_red        = sum_full[PSUM_W-1:0];
`endif

  logic [PSUM_W-1:0] s2_sum;
  logic              s2_vld;
  logic              s2_sat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_sum <= '0;
      s2_vld <= 1'b0;
      s2_sat <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      s2_sat <= s1_vld & sum_ovf;
      if (s1_vld)
        s2_sum <= sum_red;
    end
  end

  // Data only advances with a valid so the output register holds its last result.
  if (DLY == 0) begin : g_no_delay
    assign out_psum     = s2_sum;
    assign out_psum_vld = s2_vld;
    assign out_sat      = s2_sat;
  end else begin : g_delay
    logic [PSUM_W-1:0] dly_sum [DLY];
    logic [DLY-1:0]    dly_vld;
    logic [DLY-1:0]    dly_sat;

    always_ff @(posedge clk) begin
      if (!rst) begin
        dly_vld <= '0;
        dly_sat <= '0;
        for (int i = 0; i < DLY; i++) dly_sum[i] <= '0;
      end else begin
        dly_vld[0] <= s2_vld;
        dly_sat[0] <= s2_sat;
        if (s2_vld) dly_sum[0] <= s2_sum;
        for (int i = 1; i < DLY; i++) begin
          dly_vld[i] <= dly_vld[i-1];
          dly_sat[i] <= dly_sat[i-1];
          if (dly_vld[i-1]) dly_sum[i] <= dly_sum[i-1];
        end
      end
    end

    assign out_psum     = dly_sum[DLY-1];
    assign out_psum_vld = dly_vld[DLY-1];
    assign out_sat      = dly_sat[DLY-1];
  end

endmodule

`default_nettype wire

// File: tb/tb_pe_vec_mac.sv
// Self-checking bench for pe_vec_mac: directed plan followed by random operand traffic.
`default_nettype none

module tb_pe_vec_mac;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int P  = 20;
  localparam int PS = 3;
  localparam int N  = 1024;

  logic           clk = 1'b0;
  logic           rst;
  logic [L*W-1:0] in_data;
  logic [L*W-1:0] in_weight;
  logic [P-1:0]   in_psum;
  logic           du, wu, pu;
  logic [P-1:0]   out_psum;
  logic           out_psum_vld, out_drop, out_sat;

  pe_vec_mac #(.WIDTH(W), .LANES(L), .PSUM_W(P), .PIPELINE_STAGE(PS)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_weight(in_weight), .in_psum(in_psum),
    .in_data_update(du), .in_weight_update(wu), .in_psum_update(pu),
    .out_psum(out_psum), .out_psum_vld(out_psum_vld),
    .out_drop(out_drop), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int     compared   = 0;
  int     mismatched = 0;
  int     cyc        = 0;
  bit     exp_v [N];
  bit     exp_d [N];
  bit     exp_s [N];
  longint exp_p [N];
  longint last_out;
  int     wreg [L];
  bit     wok, pok;
  longint preg;
  int     z  [L];
  int     da [L];
  int     wa [L];

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference arithmetic on the mathematically exact sum.
  function automatic longint reduce(input longint s, output bit sat);
    longint mx, mn, r;
    mx  = (64'sd1 <<< (P-1)) - 1;
    mn  = -(64'sd1 <<< (P-1));
    sat = 1'b0;
    r   = s;
`ifdef PE_VEC_SAT_EN
    if (s > mx) begin sat = 1'b1; r = mx; end
    if (s < mn) begin sat = 1'b1; r = mn; end
`else
    r = s & ((64'sd1 <<< P) - 1);
    if (r > mx) r = r - (64'sd1 <<< P);
`endif
    return r;
  endfunction

  task automatic check_outputs();
    if (exp_v[cyc]) last_out = exp_p[cyc];
    check("vld",  out_psum_vld, exp_v[cyc]);
    check("drop", out_drop,     exp_d[cyc]);
    check("sat",  out_sat,      exp_s[cyc]);
    check("psum", $signed(out_psum), last_out);
  endtask

  task automatic step(input bit d_up, input bit w_up, input bit p_up,
                      input int d [L], input int w [L], input longint p);
    int     weff [L];
    longint peff, s;
    bit     fire, sat;
    int     nc;
    rst = 1'b1;
    du  = d_up;
    wu  = w_up;
    pu  = p_up;
    for (int i = 0; i < L; i++) begin
      in_data[i*W +: W]   = W'(d[i]);
      in_weight[i*W +: W] = W'(w[i]);
    end
    in_psum = P'(p);
    nc   = cyc + 1;
    fire = d_up && (wok || w_up) && (pok || p_up);
    for (int i = 0; i < L; i++) weff[i] = w_up ? w[i] : wreg[i];
    peff = p_up ? p : preg;
    if (d_up && !fire) exp_d[nc] = 1'b1;
    if (fire) begin
      s = peff;
      for (int i = 0; i < L; i++) s = s + longint'(d[i]) * longint'(weff[i]);
      exp_p[nc+PS-1] = reduce(s, sat);
      exp_s[nc+PS-1] = sat;
      exp_v[nc+PS-1] = 1'b1;
    end
    if (w_up) begin wreg = w; wok = 1'b1; end
    if (p_up) preg = p;
    if (fire) pok = 1'b0;
    else if (p_up) pok = 1'b1;
    @(posedge clk);
    cyc = nc;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, z, z, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; du = 1'b0; wu = 1'b0; pu = 1'b0;
    in_data = '0; in_weight = '0; in_psum = '0;
    @(posedge clk);
    cyc++;
    wok = 1'b0; pok = 1'b0; preg = 0;
    for (int i = 0; i < L; i++) wreg[i] = 0;
    for (int i = cyc; i < N; i++) begin
      exp_v[i] = 1'b0; exp_d[i] = 1'b0; exp_s[i] = 1'b0; exp_p[i] = 0;
    end
    last_out = 0;
    #1;
    check_outputs();
  endtask

  initial begin
    z = '{0, 0, 0, 0};
    last_out = 0;
    do_reset();
    do_reset();

    // Single op with all loads in the fire cycle.
    da = '{1, 2, 3, 4};
    wa = '{5, 6, 7, 8};
    step(1'b1, 1'b1, 1'b1, da, wa, 100);
    idle(2);
    check("single_op", $signed(out_psum), 170);
    check("single_vld", out_psum_vld, 1);
    idle(1);
    check("single_pulse", out_psum_vld, 0);

    // Stationary weights, back-to-back fires.
    wa = '{1, 1, 1, 1};
    step(1'b0, 1'b1, 1'b0, z, wa, 0);
    for (int k = 1; k <= 5; k++) begin
      da = '{k, k, k, k};
      step(1'b1, 1'b0, 1'b1, da, z, 0);
    end
    check("stream_first", $signed(out_psum), 12);
    idle(2);
    check("stream_last", $signed(out_psum), 20);
    idle(1);

    // Missing psum drops the data update.
    wa = '{3, 3, 3, 3};
    da = '{2, 2, 2, 2};
    step(1'b0, 1'b1, 1'b0, z, wa, 0);
    step(1'b1, 1'b0, 1'b0, da, z, 0);
    check("missing_drop", out_drop, 1);
    step(1'b1, 1'b0, 1'b1, da, z, 10);
    idle(2);
    check("after_drop", $signed(out_psum), 34);

    // Negative extremes.
    da = '{-128, -128, -128, -128};
    wa = '{-128, -128, -128, -128};
    step(1'b1, 1'b1, 1'b1, da, wa, 0);
    idle(2);
    check("neg_extreme", $signed(out_psum), 65536);
    da = '{-1, 2, -3, 4};
    wa = '{1, 1, 1, 1};
    step(1'b1, 1'b1, 1'b1, da, wa, -2);
    idle(2);
    check("mixed_zero", $signed(out_psum), 0);

    // Overflow of the psum range.
    da = '{-128, -128, -128, -128};
    wa = '{-128, -128, -128, -128};
    step(1'b1, 1'b1, 1'b1, da, wa, 524287);
    idle(2);
`ifdef PE_VEC_SAT_EN
    check("overflow", $signed(out_psum), 524287);
    check("overflow_sat", out_sat, 1);
`else
    check("overflow", $signed(out_psum), -458753);
    check("overflow_sat", out_sat, 0);
`endif
    idle(1);

    // Reset while a result is in flight.
    da = '{1, 1, 1, 1};
    wa = '{1, 1, 1, 1};
    step(1'b1, 1'b1, 1'b1, da, wa, 5);
    do_reset();
    idle(3);
    check("rst_flight_vld", out_psum_vld, 0);
    check("rst_flight_psum", $signed(out_psum), 0);
    step(1'b1, 1'b0, 1'b1, da, z, 5);
    check("rst_weight_drop", out_drop, 1);
    idle(1);

    // Random traffic against the reference model.
    for (int n = 0; n < 250; n++) begin
      for (int i = 0; i < L; i++) begin
        da[i] = int'($urandom_range(255)) - 128;
        wa[i] = int'($urandom_range(255)) - 128;
      end
      step(($urandom_range(3) != 0), ($urandom_range(3) == 0), ($urandom_range(1) == 1),
           da, wa, longint'($urandom_range(32'hFFFFF)) - 524288);
    end
    idle(PS + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
